// File: rtl/instruction_mem_pkg.sv
// Shared definitions for the AWG instruction store: word width, opcode/jump field layout, fetch FSM states.
// Pure constants and types; no logic, no latency, no flow control.
package awg_instr_pkg;
    localparam int DATA_W = 128;

    localparam logic [2:0] SEGMENT_OPERATION = 3'b101;
    localparam logic [2:0] JUM_OPERATION     = 3'b111;

    localparam int OPC_HI       = 127;
    localparam int OPC_LO       = 125;
    localparam int JMP_ADDR_HI  = 95;
    localparam int JMP_ADDR_LO  = 64;
    localparam int JMP_CNT_HI   = 47;
    localparam int JMP_CNT_LO   = 32;
    localparam int JMP_TIMES_HI = 15;
    localparam int JMP_TIMES_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_RESP  = 2'd2,
        ST_REARM = 2'd3
    } state_t;
endpackage

// File: rtl/instruction_mem_if.sv
// Fetch-read and host-write bundle between the fetcher/host (master) and the instruction store (slave).
// Level-held read request answered by a single read_valid/read_done pulse; writes are fire-and-forget.
interface instruction_mem_if;
    import awg_instr_pkg::*;

    logic [31:0]       axi_araddr;
    logic              axi_read_txn;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              read_done;
    logic              rd_err;
    logic              busy;
    logic              wr_en;
    logic [31:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output axi_araddr, axi_read_txn, wr_en, wr_addr, wr_data,
        input  read_data, read_valid, read_done, rd_err, busy
    );

    modport slave (
        input  axi_araddr, axi_read_txn, wr_en, wr_addr, wr_data,
        output read_data, read_valid, read_done, rd_err, busy
    );
endinterface

// File: rtl/instruction_mem_ram.sv
// Simple dual-port read-first instruction RAM with a registered read and RD_LAT-1 extra pipeline stages.
// Read data appears RD_LAT cycles after i_rd_en; the pipeline holds its value until the next i_rd_en.
module instr_ram
    import awg_instr_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [DATA_W-1:0] o_rd_dat
);
    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DATA_W-1:0] r_pipe [RD_LAT];

    // Stage 0 loads only on a read, so later writes to the same word cannot leak into the response.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_pipe[0] <= r_mem[i_rd_idx];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rd_dat = r_pipe[RD_LAT-1];
endmodule

// File: rtl/instruction_mem.sv
// Instruction-fetch responder: one 128-bit word per held request, plus an independent host write port.
// Response pulse RD_LAT+1 cycles after capture; request must drop (REARM) before a new one is taken.
module instruction_mem
    import awg_instr_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    instruction_mem_if.slave        bus
);
    localparam int LAT_W = 2;

    state_t            r_state;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [ADDR_W-1:0] r_rd_idx;
    logic              r_rd_oor;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_read_done;
    logic              r_rd_err;
    logic              r_busy;

    logic [ADDR_W-1:0] w_rd_idx;
    logic              w_rd_oor;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_wr_ok;
    logic              w_ram_rd_en;
    logic [DATA_W-1:0] w_ram_dat;
    logic              w_unused_addr_bits;

    assign w_rd_idx = bus.axi_araddr[ADDR_W+3:4];
    assign w_rd_oor = |bus.axi_araddr[31:ADDR_W+4];
    assign w_wr_idx = bus.wr_addr[ADDR_W+3:4];
    assign w_wr_ok  = bus.wr_en && ~|bus.wr_addr[31:ADDR_W+4];
    assign w_unused_addr_bits = &{1'b0, bus.axi_araddr[3:0], bus.wr_addr[3:0]};

    // The RAM is read exactly once, in the first READ cycle.
    assign w_ram_rd_en = (r_state == ST_READ) && (r_lat_cnt == LAT_W'(RD_LAT-1));

    instr_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_wr_ok),
        .i_wr_idx (w_wr_idx),
        .i_wr_dat (bus.wr_data),
        .i_rd_en  (w_ram_rd_en),
        .i_rd_idx (r_rd_idx),
        .o_rd_dat (w_ram_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= '0;
            r_rd_idx     <= '0;
            r_rd_oor     <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_read_done  <= 1'b0;
            r_rd_err     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            r_read_done  <= 1'b0;
            r_rd_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.axi_read_txn) begin
                        r_rd_idx  <= w_rd_idx;
                        r_rd_oor  <= w_rd_oor;
                        r_lat_cnt <= LAT_W'(RD_LAT-1);
                        r_busy    <= 1'b1;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (r_lat_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_read_data  <= r_rd_oor ? '0 : w_ram_dat;
                    r_read_valid <= 1'b1;
                    r_read_done  <= 1'b1;
                    r_rd_err     <= r_rd_oor;
                    r_state      <= ST_REARM;
                end
                ST_REARM: begin
                    // A request still held from the previous fetch must drop before we re-arm.
                    if (!bus.axi_read_txn) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.read_data  = r_read_data;
    assign bus.read_valid = r_read_valid;
    assign bus.read_done  = r_read_done;
    assign bus.rd_err     = r_rd_err;
    assign bus.busy       = r_busy;
endmodule

// File: doc/instruction_mem.md
Name: instruction_mem

Overview:
- Responder end of the instruction-fetch read interface.
- The fetcher raises axi_read_txn with a byte address on axi_araddr. This block reads one 128-bit instruction word from on-chip instruction RAM and returns it with read_data, read_valid and read_done.
- A separate host write port loads waveform-sheet programs (segment/jump instructions) into the RAM.

Parameters:
- DATA_W, 128, instruction word width (fixed; one instruction per word).
- DEPTH, 1024, number of instruction words.
- ADDR_W, 10, word-index width, equal to log2(DEPTH).
- RD_LAT, 2, RAM-to-response latency in cycles, legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous assert, active-high
- axi_araddr  in  32  byte address of the requested instruction, 16-byte aligned
- axi_read_txn  in  1  read request, level; held by the fetcher until after read_done
- read_data  out  128  returned instruction word
- read_valid  out  1  one-cycle pulse; read_data is valid this cycle
- read_done  out  1  one-cycle pulse, coincident with read_valid
- rd_err  out  1  one-cycle pulse with read_done when the address was out of range
- busy  out  1  high from request capture until re-arm completes
- wr_en  in  1  host write strobe
- wr_addr  in  32  host byte address, 16-byte aligned
- wr_data  in  128  host write data

Behaviour:
- Reset (async, rst=1): state=IDLE. read_data=0, read_valid=0, read_done=0, rd_err=0, busy=0. RAM contents are not cleared.
- Word index: addr[ADDR_W+3:4]. Bits [3:0] are ignored.
- Out of range: any of bits [31:ADDR_W+4] nonzero.
  - Read: returns read_data=0 with rd_err=1.
  - Write: dropped silently.
- FSM, state IDLE:
  - If axi_read_txn=1: capture the word index and the range check, then go to READ with lat_cnt=RD_LAT-1 and busy=1.
- FSM, state READ:
  - RAM read is issued in the first READ cycle.
  - lat_cnt decrements each cycle; at 0 go to RESP.
- FSM, state RESP (exactly one cycle):
  - read_data is registered; read_valid=read_done=1; rd_err=1 if out of range.
  - Go to REARM.
- FSM, state REARM:
  - Wait for axi_read_txn=0, then go to IDLE and drop busy.
  - A txn still high after read_done is never treated as a new request. This covers the fetcher's one-cycle-late deassert.
- Latency: from the first clk edge sampling axi_read_txn=1 in IDLE to the read_valid cycle is RD_LAT+1 cycles.
- read_data holds its last value after RESP. It is updated only in RESP.
- Write port:
  - Independent of the FSM; accepted in any state, one word per cycle.
  - Write and read to the same word in the first READ cycle is read-first: the read returns the old data.
  - A write in any later READ cycle does not affect the returned data.
- axi_araddr changes after capture are ignored.
- rst asserted mid-read:
  - Response is aborted with no pulse; outputs go to reset values immediately.
  - After rst deasserts, a txn that is still high starts a fresh read.

Decomposition:
- Shared package awg_instr_pkg holds:
  - DATA_W.
  - Opcode constants SEGMENT_OPERATION=3'b101 and JUM_OPERATION=3'b111, field positions [127:125].
  - Jump-field slices: addr [95:64], counter [47:32], times [15:0].
  - FSM state encoding for this block.
- One sub-module, instr_ram:
  - Simple dual-port RAM, DEPTH x DATA_W, read-first.
  - Write port: synchronous.
  - Read port: registered output; the remaining RD_LAT-1 stages are pipeline registers inside this module.

Test Plan:
- Load word 0=0xA000..01 (segment) via wr_en at addr 0x0. Raise txn with araddr=0x0, RD_LAT=2 -> read_valid=read_done=1 exactly 3 cycles after capture, read_data=0xA000..01, rd_err=0.
- Hold txn high 5 cycles after read_done -> no second pulse, busy stays 1. Drop txn -> busy=0 next cycle. Raise txn with araddr=0x10 -> word 1 returned.
- araddr=0x4000 (DEPTH=1024) -> read_data=0, rd_err=1 together with read_done. A write to 0x4000 leaves all words unchanged.
- Write 0xFFFF..FF to word 2 in the same cycle as the first READ cycle of a word-2 read (old data 0x1234) -> returns 0x1234. The next read of word 2 returns 0xFFFF..FF.
- Assert rst 1 cycle into READ -> no read_valid, all outputs 0 asynchronously. Release rst with txn high -> full read completes normally.
- Jump sequence: words 0=seg, 1=jump(addr 0x0, counter 1, times 2), 2=seg, driven by a fetcher model -> fetch order 0,1,0,1,0,1,2, every response RD_LAT+1 after its capture.
